// File: rtl/sa_sync_filt_nd_if.sv
// Bus bundle for sa_sync_filt_nd: raw inputs, filtered level, edge pulses and sticky flags.
interface sa_sync_filt_nd_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_rise;
  logic [WIDTH-1:0] q_fall;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] chg_clr;
  logic [WIDTH-1:0] chg;

  modport master (
    output d, chg_clr,
    input  q, q_rise, q_fall, s_raw, chg
  );

  modport slave (
    input  d, chg_clr,
    output q, q_rise, q_fall, s_raw, chg
  );
endinterface

// File: rtl/sa_sync_filt_nd.sv
// Per-bit N-stage synchroniser, consecutive-cycle glitch filter and registered edge detect.
// Optional sticky change flags are built when SA_SYNC_FILT_STICKY_EN is defined.
module sa_sync_filt_nd #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned FILT_CNT  = 4,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  sa_sync_filt_nd_if.slave bus
);

  localparam int unsigned CNT_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT - 1);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("sa_sync_filt_nd: STAGES must be in 2..8");
  end
  if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_filt
    $error("sa_sync_filt_nd: FILT_CNT must be in 1..255");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             s_raw;
  logic [WIDTH-1:0]             q_q, q_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;
  logic [CNT_W-1:0]             cnt_q [WIDTH];
  logic [CNT_W-1:0]             cnt_d [WIDTH];

  assign s_raw = sync_q[STAGES-1];

  // Synchroniser shift chain; stage 0 captures the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VEC}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], bus.d};
    end
  end

  // q only follows s_raw after FILT_CNT consecutive mismatching samples.
  always_comb begin
    q_d = q_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_raw[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_MAX) begin
        q_d[i]   = s_raw[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = q_d & ~q_q;
    fall_d = q_q & ~q_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_VEC;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.q      = q_q;
  assign bus.q_rise = rise_q;
  assign bus.q_fall = fall_q;
  assign bus.s_raw  = s_raw;

`ifdef SA_SYNC_FILT_STICKY_EN
  logic [WIDTH-1:0] chg_q, chg_d;

  // A new edge pulse outranks a clear in the same cycle.
  assign chg_d = (chg_q & ~bus.chg_clr) | rise_q | fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign bus.chg = chg_q;
`else
  logic unused_chg_clr;

  assign unused_chg_clr = ^bus.chg_clr;
  assign bus.chg        = '0;
`endif

endmodule

// File: tb/tb_sa_sync_filt_nd.sv
// Directed self-checking bench for sa_sync_filt_nd across three parameter sets.
module tb_sa_sync_filt_nd;

`ifdef SA_SYNC_FILT_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sa_sync_filt_nd_if #(.WIDTH(4)) bus_a ();
  sa_sync_filt_nd_if #(.WIDTH(8)) bus_b ();
  sa_sync_filt_nd_if #(.WIDTH(1)) bus_c ();

  sa_sync_filt_nd #(.WIDTH(4), .STAGES(3), .FILT_CNT(4), .RESET_VAL(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  sa_sync_filt_nd #(.WIDTH(8), .STAGES(3), .FILT_CNT(4), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );
  sa_sync_filt_nd #(.WIDTH(1), .STAGES(2), .FILT_CNT(1), .RESET_VAL(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .bus(bus_c)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] q, input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.q = q; e.rise = r; e.fall = f;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] q, input logic [7:0] r,
                         input logic [7:0] f);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_rise"}, r, e.rise);
      chk({tag, "_fall"}, f, e.fall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       dq[$];
    logic       e_c, prev_c;
    logic [7:0] seen_q, seen_r;
    int         npulse;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.d = '0; bus_b.d = '0; bus_c.d = '0;
    bus_a.chg_clr = '0; bus_b.chg_clr = '0; bus_c.chg_clr = '0;
    tick(3);

    // Reset hold: set-type reset value despite d=0.
    push(8'h0F, 8'h00, 8'h00);
    pop_chk("a_rst", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    chk("a_rst_sraw", 8'(bus_a.s_raw), 8'h0F);
    chk("a_rst_chg", 8'(bus_a.chg), 8'h00);
    push(8'h00, 8'h00, 8'h00);
    pop_chk("b_rst", bus_b.q, bus_b.q_rise, bus_b.q_fall);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    push(8'h0F, 8'h00, 8'h00);
    push(8'h00, 8'h00, 8'h0F);
    push(8'h00, 8'h00, 8'h00);
    tick(6);
    pop_chk("a_rel6", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    tick(1);
    pop_chk("a_rel7", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    tick(1);
    pop_chk("a_rel8", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));

    // Glitch of 3 cycles on bit 0 of B must be rejected.
    bus_b.d = 8'h01;
    tick(3);
    chk("b_gl3_sraw", bus_b.s_raw, 8'h01);
    bus_b.d = 8'h00;
    seen_q = '0; seen_r = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_q |= bus_b.q;
      seen_r |= bus_b.q_rise;
    end
    chk("b_gl3_q", seen_q, 8'h00);
    chk("b_gl3_rise", seen_r, 8'h00);

    // 4-cycle pulse passes: q rises at edge 7, falls again at edge 11.
    bus_b.d = 8'h01;
    push(8'h00, 8'h00, 8'h00);
    push(8'h01, 8'h01, 8'h00);
    push(8'h01, 8'h00, 8'h00);
    push(8'h00, 8'h00, 8'h01);
    tick(4);
    bus_b.d = 8'h00;
    tick(2);
    pop_chk("b_gl4_e6", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(1);
    pop_chk("b_gl4_e7", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(1);
    pop_chk("b_gl4_e8", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(3);
    pop_chk("b_gl4_e11", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(4);

    // Independent bits: 00 -> A5.
    bus_b.d = 8'hA5;
    push(8'h00, 8'h00, 8'h00);
    push(8'hA5, 8'hA5, 8'h00);
    push(8'hA5, 8'h00, 8'h00);
    tick(6);
    pop_chk("b_a5_e6", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(1);
    pop_chk("b_a5_e7", bus_b.q, bus_b.q_rise, bus_b.q_fall);
    tick(1);
    pop_chk("b_a5_e8", bus_b.q, bus_b.q_rise, bus_b.q_fall);

    // No filtering: q is d delayed by 3 edges, one pulse per toggle.
    prev_c = 1'b0;
    npulse = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0 && (k % 5) == 0) bus_c.d = ~bus_c.d;
      dq.push_back(bus_c.d[0]);
      tick(1);
      if (bus_c.q_rise[0] || bus_c.q_fall[0]) npulse++;
      if (dq.size() == 3) begin
        e_c = dq.pop_front();
        chk($sformatf("c_nf%0d_q", k), 8'(bus_c.q), 8'(e_c));
        chk($sformatf("c_nf%0d_rise", k), 8'(bus_c.q_rise), 8'(e_c & ~prev_c));
        chk($sformatf("c_nf%0d_fall", k), 8'(bus_c.q_fall), 8'(prev_c & ~e_c));
        prev_c = e_c;
      end
    end
    chk("c_nf_npulse", 8'(npulse), 8'd4);

    // Async reset while bit 0 of A has cnt=2.
    bus_a.d = 4'h1;
    tick(5);
    #2;
    rst_a = 1'b1;
    bus_a.d = 4'hF;
    #1;
    push(8'h0F, 8'h00, 8'h00);
    pop_chk("a_arst", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    chk("a_arst_sraw", 8'(bus_a.s_raw), 8'h0F);
    chk("a_arst_chg", 8'(bus_a.chg), 8'h00);
    tick(2);
    rst_a = 1'b0;
    seen_r = '0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      seen_r |= 8'(bus_a.q_rise | bus_a.q_fall);
    end
    chk("a_arst_nopulse", seen_r, 8'h00);

    // Counter restarted from 0: fall takes the full 7 edges.
    bus_a.d = 4'hE;
    push(8'h0F, 8'h00, 8'h00);
    push(8'h0E, 8'h00, 8'h01);
    push(8'h0E, 8'h00, 8'h00);
    tick(6);
    pop_chk("a_cnt_e6", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    tick(1);
    pop_chk("a_cnt_e7", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    tick(1);
    pop_chk("a_cnt_e8", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    chk("a_chg_set", 8'(bus_a.chg), STICKY ? 8'h01 : 8'h00);

    // Rise with coincident clear keeps chg; a lone clear then drops it.
    bus_a.d = 4'hF;
    push(8'h0F, 8'h01, 8'h00);
    tick(7);
    pop_chk("a_rise_e7", 8'(bus_a.q), 8'(bus_a.q_rise), 8'(bus_a.q_fall));
    bus_a.chg_clr = 4'h1;
    tick(1);
    chk("a_chg_setwins", 8'(bus_a.chg), STICKY ? 8'h01 : 8'h00);
    tick(1);
    chk("a_chg_clr", 8'(bus_a.chg), 8'h00);
    bus_a.chg_clr = 4'h0;
    tick(2);
    chk("a_chg_hold", 8'(bus_a.chg), 8'h00);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_sync_filt_nd.md
Name: sa_sync_filt_nd

Overview:
- Parametrised multi-bit synchroniser for asynchronous level inputs: a per-bit N-stage flop chain followed by a per-bit glitch filter and registered edge detect.
- Replaces the fixed 3-stage single-bit synchroniser cells at debounced control and status inputs such as straps, interrupts and handshakes.
- Each bit is independent.
- No multi-bit coherency is provided; vectors needing coherency go through a handshake FIFO instead.

Parameters:
- WIDTH, 1, number of independent bits synchronised.
- STAGES, 3, synchroniser flops per bit. Legal range 2..8.
- FILT_CNT, 4, consecutive cycles the synchronised value must differ from q before q changes. Legal range 1..255; 1 disables filtering.
- RESET_VAL, 1, value loaded into every sync flop and q on reset; replicated across WIDTH. The default matches set-type sync cells.

Ports:
- clk  input  1  sampling clock.
- rst  input  1  asynchronous reset, active-high.
- d  input  WIDTH  asynchronous level inputs.
- q  output  WIDTH  synchronised, filtered level.
- q_rise  output  WIDTH  one-cycle pulse in the cycle q goes 0->1.
- q_fall  output  WIDTH  one-cycle pulse in the cycle q goes 1->0.
- s_raw  output  WIDTH  last sync stage, before filtering; for debug and bypass use.
- chg_clr  input  WIDTH  clears the matching chg bit (feature only).
- chg  output  WIDTH  sticky change flag (feature only).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high: assertion takes effect immediately, independent of clk; deassertion is released on a clk edge by the surrounding reset logic.
- Reset values:
  - all sync flops = RESET_VAL.
  - q = RESET_VAL, s_raw = RESET_VAL.
  - filter counters = 0.
  - q_rise = q_fall = 0; chg = 0.
- Sync chain: d is captured into stage 0 on each clk rising edge and shifts one stage per edge. s_raw is stage STAGES-1. A d change is visible on s_raw after STAGES edges.
- Filter, per bit, with cnt of width clog2(FILT_CNT), minimum 1 bit:
  - s_raw == q: cnt <= 0.
  - s_raw != q and cnt < FILT_CNT-1: cnt <= cnt+1.
  - s_raw != q and cnt == FILT_CNT-1: q <= s_raw, cnt <= 0.
  - cnt never exceeds FILT_CNT-1 and never wraps.
- Latency: a d change held stable reaches q on edge STAGES+FILT_CNT after its first capture edge.
- Glitch rejection: a pulse on s_raw shorter than FILT_CNT cycles never changes q. The counter restarts from 0 on the next mismatch.
- Edge pulses are registered and updated on the same edge as q:
  - q_rise is 1 for exactly one cycle when q goes 0->1.
  - q_fall is 1 for exactly one cycle when q goes 1->0.
  - q_rise and q_fall are never both 1 on the same bit.
- Reset mid-operation: all state returns to reset values at once. No edge pulse is generated by reset, even if q had a different value before.
- FILT_CNT=1: q follows s_raw with one cycle of delay. Filtering is inert.
- Illegal parameters (STAGES<2, FILT_CNT<1 or >255): elaboration-time error.

Optional Feature:
- Macro: SA_SYNC_FILT_STICKY_EN.
- Defined:
  - chg[i] is set on any cycle where q_rise[i] or q_fall[i] is 1.
  - chg[i] is cleared when chg_clr[i] is 1.
  - Set wins over clear in the same cycle.
  - Reset value 0.
- Not defined: chg is tied to 0, chg_clr is ignored, and no flops are inferred.

Test Plan:
- Reset hold: WIDTH=4, RESET_VAL=1, d=0 held during reset -> q=4'hF, s_raw=4'hF, q_rise=q_fall=0. After release, bit falls with q_fall=1 for 1 cycle, exactly 3+4=7 edges after first capture.
- Glitch reject: STAGES=3, FILT_CNT=4, q=0, d=1 for 3 cycles then 0 -> s_raw pulses 3 cycles, q stays 0, no q_rise. Repeat with 4 cycles -> q=1 for at least 1 cycle, q_rise single pulse.
- No filtering: FILT_CNT=1, STAGES=2, toggle d every 5 cycles -> q mirrors d delayed 3 edges. One q_rise or q_fall per toggle.
- Independent bits: WIDTH=8, d 8'h00->8'hA5 held -> q=8'hA5 after STAGES+FILT_CNT edges. q_rise=8'hA5 for one cycle, q_fall=8'h00.
- Async reset mid-filter: cnt=2 on a changing bit, assert rst between edges -> q, s_raw and counters at reset values before the next clk edge; no pulses after release.
- Sticky (SA_SYNC_FILT_STICKY_EN): a q_rise sets chg=1. chg_clr with no change clears chg next cycle. chg_clr coincident with a new edge leaves chg=1. Without the macro, chg stays 0 throughout.
